// File: rtl/div_pkg.sv
// Shared definitions for the sequential divider.
//   state_bits_t : 2-bit raw state encoding, also driven on the debug port
//   state_e      : FSM states IDLE(0) -> LOAD(1) -> CALC(2) -> DONE(3)
//   cnt_width()  : width of the step counter for a given operand width
package div_pkg;

  typedef logic [1:0] state_bits_t;

  typedef enum state_bits_t {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CALC = 2'd2,
    DONE = 2'd3
  } state_e;

  // The counter must hold WIDTH-1; never narrower than one bit.
  function automatic int cnt_width(input int w);
    return (w <= 2) ? 1 : $clog2(w);
  endfunction

endpackage

// File: rtl/div_addsub.sv
// (N+1)-bit subtractor: {borrow_o, diff_o} = a_i - b_i.
// Used as the trial subtractor of the divider core and, in the signed
// build (DIVIDER_SIGNED_EN), as a two's-complement negator (a_i = 0).
// Ports:
//   a_i, b_i  in  N+1  minuend / subtrahend
//   diff_o    out N    low N bits of the difference
//   borrow_o  out 1    top bit of the difference (set when a_i < b_i,
//                      given both operands fit in N bits + 1)
module div_addsub #(
  parameter int N = 8
) (
  input  logic [N:0]   a_i,
  input  logic [N:0]   b_i,
  output logic [N-1:0] diff_o,
  output logic         borrow_o
);

  logic [N:0] res;

  assign res      = a_i - b_i;
  assign diff_o   = res[N-1:0];
  assign borrow_o = res[N];

endmodule

// File: rtl/seq_divider_param.sv
// Parametrised restoring shift/subtract divider, one quotient bit per cycle.
// Optional feature macro: DIVIDER_SIGNED_EN (two's-complement operands and
// results, truncation toward zero, remainder takes the dividend's sign).
// Ports:
//   clk, rst            clock, synchronous active-low reset
//   start               request; accepted only in IDLE
//   dividend, divisor   operands, sampled on the accept cycle
//   busy                high in LOAD and CALC
//   done                one-cycle pulse in DONE, results valid
//   quotient, remainder results, held until the next result
//   div_by_zero         set with done for divisor==0, cleared on next accept
//   state               FSM state for debug
// Handshake: start is sampled only while in IDLE; each accepted start
// produces exactly one done pulse unless reset intervenes.
module seq_divider_param
  import div_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       state
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;       // dividend, becomes quotient
  logic [WIDTH-1:0] b_q, b_d;       // divisor
  logic [WIDTH-1:0] p_q, p_d;       // partial remainder (always < B)
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] quot_q, quot_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             dbz_q, dbz_d;

  // One restoring step: the shifted pair {P,A} gives a WIDTH+1-bit partial
  // remainder; a clear top bit of the trial difference means it fits.
  logic [WIDTH:0]   shift_p;
  logic [WIDTH-1:0] trial;
  logic             trial_neg;
  logic [WIDTH-1:0] step_a, step_p;
  logic [WIDTH-1:0] q_res, r_res;

  assign shift_p = {p_q, a_q[WIDTH-1]};

  div_addsub #(.N(WIDTH)) u_trial (
    .a_i      (shift_p),
    .b_i      ({1'b0, b_q}),
    .diff_o   (trial),
    .borrow_o (trial_neg)
  );

  assign step_a = {a_q[WIDTH-2:0], ~trial_neg};
  assign step_p = trial_neg ? shift_p[WIDTH-1:0] : trial;

`ifdef DIVIDER_SIGNED_EN
  logic             neg_q_q, neg_q_d;   // quotient negated when signs differ
  logic             neg_r_q, neg_r_d;   // remainder follows dividend sign
  logic [WIDTH-1:0] a_neg, b_neg, q_neg, r_neg;
  logic [3:0]       neg_borrow;

  div_addsub #(.N(WIDTH)) u_neg_a (.a_i('0), .b_i({1'b0, a_q}),
    .diff_o(a_neg), .borrow_o(neg_borrow[0]));
  div_addsub #(.N(WIDTH)) u_neg_b (.a_i('0), .b_i({1'b0, b_q}),
    .diff_o(b_neg), .borrow_o(neg_borrow[1]));
  div_addsub #(.N(WIDTH)) u_neg_q (.a_i('0), .b_i({1'b0, step_a}),
    .diff_o(q_neg), .borrow_o(neg_borrow[2]));
  div_addsub #(.N(WIDTH)) u_neg_r (.a_i('0), .b_i({1'b0, step_p}),
    .diff_o(r_neg), .borrow_o(neg_borrow[3]));

  assign q_res = neg_q_q ? q_neg : step_a;
  assign r_res = neg_r_q ? r_neg : step_p;
`else
  assign q_res = step_a;
  assign r_res = step_p;
`endif

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    p_d     = p_q;
    cnt_d   = cnt_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    neg_q_d = neg_q_q;
    neg_r_d = neg_r_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          a_d     = dividend;
          b_d     = divisor;
          p_d     = '0;
          dbz_d   = 1'b0;
`ifdef DIVIDER_SIGNED_EN
          neg_q_d = dividend[WIDTH-1] ^ divisor[WIDTH-1];
          neg_r_d = dividend[WIDTH-1];
`endif
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (b_q == '0) begin
          // A still holds the raw dividend here, in both builds.
          quot_d  = '1;
          rem_d   = a_q;
          dbz_d   = 1'b1;
          state_d = DONE;
        end else begin
`ifdef DIVIDER_SIGNED_EN
          // Magnitudes; -2^(W-1) maps to itself, read as unsigned.
          a_d = a_q[WIDTH-1] ? a_neg : a_q;
          b_d = b_q[WIDTH-1] ? b_neg : b_q;
`endif
          cnt_d   = CW'(WIDTH - 1);
          state_d = CALC;
        end
      end
      CALC: begin
        a_d = step_a;
        p_d = step_p;
        if (cnt_q == '0) begin
          // Results are registered on entry to DONE so they are valid
          // for the whole done cycle and hold afterwards.
          quot_d  = q_res;
          rem_d   = r_res;
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      p_q     <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      rem_q   <= '0;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q <= 1'b0;
      neg_r_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      p_q     <= p_d;
      cnt_q   <= cnt_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      neg_q_q <= neg_q_d;
      neg_r_q <= neg_r_d;
`endif
    end
  end

  assign busy        = (state_q == LOAD) || (state_q == CALC);
  assign done        = (state_q == DONE);
  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign state       = state_q;

endmodule

// File: tb/tb_seq_divider_param.sv
// Directed testbench for seq_divider_param at WIDTH=8.
// Latency is counted in falling edges after the accept edge: the first
// falling edge after accept is cycle N+1, so done is expected at count 10
// (WIDTH+2) for a normal division and at count 2 for divide-by-zero.
module tb_seq_divider_param;

  localparam int W = 8;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend;
  logic [W-1:0] divisor;
  logic         busy;
  logic         done;
  logic [W-1:0] quotient;
  logic [W-1:0] remainder;
  logic         div_by_zero;
  logic [1:0]   state;

  int checks = 0;
  int errors = 0;

  seq_divider_param #(.WIDTH(W)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .busy        (busy),
    .done        (done),
    .quotient    (quotient),
    .remainder   (remainder),
    .div_by_zero (div_by_zero),
    .state       (state)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Driver: issue one start, then observe until done (bounded). Returns
  // observations only; each test compares them against its own values.
  task automatic run_op(input logic [W-1:0] n, input logic [W-1:0] d,
                        output int lat, output logic [W-1:0] q,
                        output logic [W-1:0] r, output logic dz,
                        output logic pulse_low);
    lat = 0; q = '0; r = '0; dz = 1'b0; pulse_low = 1'b0;
    @(negedge clk);
    start = 1'b1; dividend = n; divisor = d;
    @(posedge clk);
    #1;
    start = 1'b0;
    dividend = W'($urandom_range(0, 255));
    divisor  = W'($urandom_range(0, 255));
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        lat = c; q = quotient; r = remainder; dz = div_by_zero;
        break;
      end
    end
    if (lat != 0) begin
      @(negedge clk);
      pulse_low = (done === 1'b0);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if ({busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL reset_flags: got %b expected 000", {busy, done, div_by_zero}); end
    checks++; if ({quotient, remainder} !== '0) begin errors++; $display("FAIL reset_results: got q=%0d r=%0d expected 0 0", quotient, remainder); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd200; divisor = 8'd7;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 1) begin
        checks++; if (state !== 2'd1 || busy !== 1'b1) begin errors++; $display("FAIL basic_load: got state=%0d busy=%b expected 1 1", state, busy); end
      end
      if (c == 2) begin
        checks++; if (state !== 2'd2 || busy !== 1'b1) begin errors++; $display("FAIL basic_calc: got state=%0d busy=%b expected 2 1", state, busy); end
      end
      if (done === 1'b1) begin lat = c; break; end
    end
    checks++; if (lat != 10) begin errors++; $display("FAIL basic_latency: got %0d expected 10", lat); end
    checks++; if (quotient !== 8'd28 || remainder !== 8'd4 || div_by_zero !== 1'b0) begin errors++; $display("FAIL basic_result: got q=%0d r=%0d dz=%b expected 28 4 0", quotient, remainder, div_by_zero); end
    @(negedge clk);
    checks++; if (done !== 1'b0 || quotient !== 8'd28) begin errors++; $display("FAIL basic_hold: got done=%b q=%0d expected 0 28", done, quotient); end
  endtask

  task automatic test_div_zero();
    int lat; logic [W-1:0] q, r; logic dz, pl;
    run_op(8'd37, 8'd0, lat, q, r, dz, pl);
    checks++; if (lat != 2) begin errors++; $display("FAIL dz_latency: got %0d expected 2", lat); end
    checks++; if (q !== 8'hFF || r !== 8'd37 || dz !== 1'b1) begin errors++; $display("FAIL dz_result: got q=%0d r=%0d dz=%b expected 255 37 1", q, r, dz); end
    checks++; if (pl !== 1'b1 || div_by_zero !== 1'b1) begin errors++; $display("FAIL dz_pulse_hold: got pulse_low=%b dz=%b expected 1 1", pl, div_by_zero); end
    run_op(8'd9, 8'd3, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'd3 || r !== 8'd0 || dz !== 1'b0) begin errors++; $display("FAIL dz_clear: got lat=%0d q=%0d r=%0d dz=%b expected 10 3 0 0", lat, q, r, dz); end
  endtask

  task automatic test_boundaries();
    int lat; logic [W-1:0] q, r; logic dz, pl;
    run_op(8'd255, 8'd1, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'd255 || r !== 8'd0 || pl !== 1'b1) begin errors++; $display("FAIL bound_255_1: got lat=%0d q=%0d r=%0d pl=%b expected 10 255 0 1", lat, q, r, pl); end
    run_op(8'd5, 8'd9, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'd0 || r !== 8'd5) begin errors++; $display("FAIL bound_5_9: got lat=%0d q=%0d r=%0d expected 10 0 5", lat, q, r); end
    run_op(8'd255, 8'd255, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'd1 || r !== 8'd0) begin errors++; $display("FAIL bound_255_255: got lat=%0d q=%0d r=%0d expected 10 1 0", lat, q, r); end
    run_op(8'd128, 8'd3, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'd42 || r !== 8'd2) begin errors++; $display("FAIL bound_128_3: got lat=%0d q=%0d r=%0d expected 10 42 2", lat, q, r); end
  endtask

  task automatic test_busy_ignore();
    int lat;
    lat = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (c == 4) begin
        start = 1'b1; dividend = 8'd50; divisor = 8'd5;
        @(posedge clk);
        #1 start = 1'b0;
      end
      if (done === 1'b1) begin lat = c; break; end
    end
    checks++; if (lat != 10 || quotient !== 8'd33 || remainder !== 8'd1) begin errors++; $display("FAIL busy_ignore: got lat=%0d q=%0d r=%0d expected 10 33 1", lat, quotient, remainder); end
  endtask

  task automatic test_reset_mid();
    int seen;
    seen = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd100; divisor = 8'd3;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= 5; c++) begin
      @(negedge clk);
      if (c == 5) rst = 1'b0;
    end
    @(negedge clk);
    checks++; if (state !== 2'd0 || {busy, done, div_by_zero} !== 3'b000) begin errors++; $display("FAIL midreset_ctrl: got state=%0d flags=%b expected 0 000", state, {busy, done, div_by_zero}); end
    checks++; if (quotient !== 8'd0 || remainder !== 8'd0) begin errors++; $display("FAIL midreset_results: got q=%0d r=%0d expected 0 0", quotient, remainder); end
    rst = 1'b1;
    for (int c = 0; c < 15; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen++;
    end
    checks++; if (seen != 0) begin errors++; $display("FAIL midreset_no_done: got %0d pulses expected 0", seen); end
  endtask

  task automatic test_back_to_back();
    int first, second;
    first = 0; second = 0;
    @(negedge clk);
    start = 1'b1; dividend = 8'd91; divisor = 8'd10;
    @(posedge clk);
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (done === 1'b1 && first == 0) begin
        first = c;
        checks++; if (quotient !== 8'd9 || remainder !== 8'd1) begin errors++; $display("FAIL b2b_first: got q=%0d r=%0d expected 9 1", quotient, remainder); end
        dividend = 8'd50; divisor = 8'd5;
      end else if (first != 0 && c == first + 1) begin
        checks++; if (state !== 2'd0) begin errors++; $display("FAIL b2b_done_start_ignored: got state=%0d expected 0", state); end
      end else if (first != 0 && c == first + 2) begin
        checks++; if (state !== 2'd1) begin errors++; $display("FAIL b2b_held_start_accepted: got state=%0d expected 1", state); end
        start = 1'b0;
      end else if (done === 1'b1 && first != 0) begin
        second = c;
        break;
      end
    end
    start = 1'b0;
    checks++; if (first != 10 || second != 21) begin errors++; $display("FAIL b2b_latency: got %0d %0d expected 10 21", first, second); end
    checks++; if (quotient !== 8'd10 || remainder !== 8'd0) begin errors++; $display("FAIL b2b_second: got q=%0d r=%0d expected 10 0", quotient, remainder); end
  endtask

`ifdef DIVIDER_SIGNED_EN
  task automatic test_signed();
    int lat; logic [W-1:0] q, r; logic dz, pl;
    run_op(8'hF9, 8'd2, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'hFD || r !== 8'hFF) begin errors++; $display("FAIL signed_m7_2: got lat=%0d q=%h r=%h expected 10 fd ff", lat, q, r); end
    run_op(8'd7, 8'hFE, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'hFD || r !== 8'h01) begin errors++; $display("FAIL signed_7_m2: got lat=%0d q=%h r=%h expected 10 fd 01", lat, q, r); end
    run_op(8'h80, 8'hFF, lat, q, r, dz, pl);
    checks++; if (lat != 10 || q !== 8'h80 || r !== 8'h00) begin errors++; $display("FAIL signed_m128_m1: got lat=%0d q=%h r=%h expected 10 80 00", lat, q, r); end
  endtask
`endif

  initial begin
    rst = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
    test_reset();
    test_div_zero();
`ifdef DIVIDER_SIGNED_EN
    test_signed();
`else
    test_basic();
    test_boundaries();
    test_busy_ignore();
    test_back_to_back();
`endif
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
